// File: rtl/fei4_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fei4_rx_pkg
//  Purpose : Shared constants and types for the FE-I4 receive frame assembler:
//            comma K-codes, FSM state encoding, record and counter widths.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package fei4_rx_pkg;

    // Comma symbols seen on the decoded stream (all carried with K=1)
    localparam logic [7:0] K28_7 = 8'hFC;   // start of frame
    localparam logic [7:0] K28_5 = 8'hBC;   // end of frame
    localparam logic [7:0] K28_1 = 8'h3C;   // idle filler

    localparam int REC_W = 24;              // one FE-I4 record = 3 bytes
    localparam int CNT_W = 8;               // error counter width

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } rx_state_t;

endpackage : fei4_rx_pkg
`default_nettype wire

// File: rtl/sat_counter8.sv
`default_nettype none
// ============================================================================
//  Module  : sat_counter8
//  Purpose : 8-bit counter that sticks at its maximum value instead of wrapping.
//  Ports   : clk   - clock
//            clear - synchronous clear, dominant over inc
//            inc   - add one this cycle (ignored once saturated)
//            value - current count
//  Revision: 1.0 - initial release
// ============================================================================
module sat_counter8
    import fei4_rx_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (clear) begin
            value <= '0;
        end else if (inc && (value != {CNT_W{1'b1}})) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule : sat_counter8
`default_nettype wire

// File: rtl/fei4_rx_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module  : fei4_rx_frame_assembler
//  Purpose : Tracks SOF/EOF comma framing on the decoded 8b10b stream, packs
//            data bytes into 24-bit records and writes them to the record
//            FIFO. Counts decoder, framing and FIFO-overflow losses.
//  Params  : MAX_REC - records allowed per frame before a data byte is
//            treated as a framing error.
//  Config  : FEI4_RX_SOF_FLAG_EN - when defined, REC_SOF marks the first
//            record written after each SOF; otherwise REC_SOF is tied to 0.
//  Ports   : WCLK, RESET (sync, active-high), ENABLE
//            DEC_VALID, DEC_DATA[7:0], DEC_K, DEC_CODE_ERR  - decoder side
//            FIFO_FULL, FIFO_WRITE, FIFO_DATA[23:0], REC_SOF - FIFO side
//            IN_FRAME, DECODER_ERR_CNT, FRAME_ERR_CNT, LOST_ERR_CNT - status
//  Revision: 1.0 - initial release
// ============================================================================
module fei4_rx_frame_assembler
    import fei4_rx_pkg::*;
#(
    parameter int MAX_REC = 255
)(
    input  logic             WCLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             DEC_VALID,
    input  logic [7:0]       DEC_DATA,
    input  logic             DEC_K,
    input  logic             DEC_CODE_ERR,
    input  logic             FIFO_FULL,
    output logic             FIFO_WRITE,
    output logic [REC_W-1:0] FIFO_DATA,
    output logic             REC_SOF,
    output logic             IN_FRAME,
    output logic [CNT_W-1:0] DECODER_ERR_CNT,
    output logic [CNT_W-1:0] FRAME_ERR_CNT,
    output logic [CNT_W-1:0] LOST_ERR_CNT
);

    localparam int                   REC_CNT_W = $clog2(MAX_REC + 1);
    localparam logic [REC_CNT_W-1:0] REC_LIMIT = REC_CNT_W'(MAX_REC);

    rx_state_t              r_state;
    logic [1:0]             r_idx;
    logic [REC_CNT_W-1:0]   r_rec_cnt;
    logic [7:0]             r_byte0;
    logic [7:0]             r_byte1;

    logic w_active;      // valid, enabled, error-free symbol
    logic w_in_frame;
    logic w_sof;
    logic w_eof;
    logic w_idle_k;
    logic w_unknown_k;
    logic w_data;
    logic w_rec_full;    // frame already holds MAX_REC records
    logic w_complete;    // this byte completes a record
    logic w_write;
    logic w_dec_err_inc;
    logic w_frame_err_inc;
    logic w_lost_inc;

    always_comb begin
        w_active        = ENABLE && DEC_VALID && !DEC_CODE_ERR;
        w_in_frame      = (r_state == FRAME);
        w_sof           = w_active && DEC_K && (DEC_DATA == K28_7);
        w_eof           = w_active && DEC_K && (DEC_DATA == K28_5);
        w_idle_k        = w_active && DEC_K && (DEC_DATA == K28_1);
        w_unknown_k     = w_active && DEC_K && !w_sof && !w_eof && !w_idle_k;
        w_data          = w_active && !DEC_K;
        w_rec_full      = (r_rec_cnt == REC_LIMIT);
        w_complete      = w_data && w_in_frame && !w_rec_full && (r_idx == 2'd2);
        w_write         = w_complete && !FIFO_FULL;
        w_lost_inc      = w_complete && FIFO_FULL;
        w_dec_err_inc   = ENABLE && DEC_VALID && DEC_CODE_ERR;
        // All framing-error sources collapse into one increment per cycle
        w_frame_err_inc = (w_data && !w_in_frame)
                       || (w_eof  && !w_in_frame)
                       || (w_eof  &&  w_in_frame && (r_idx != 2'd0))
                       || (w_sof  &&  w_in_frame)
                       || (w_unknown_k && w_in_frame)
                       || (w_data &&  w_in_frame && w_rec_full);
    end

    assign IN_FRAME = w_in_frame;

    // Framing FSM and record packer
    always_ff @(posedge WCLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_idx      <= 2'd0;
            r_rec_cnt  <= '0;
            r_byte0    <= 8'd0;
            r_byte1    <= 8'd0;
            FIFO_WRITE <= 1'b0;
            FIFO_DATA  <= '0;
        end else begin
            FIFO_WRITE <= 1'b0;
            if (!ENABLE) begin
                r_state <= IDLE;
                r_idx   <= 2'd0;
            end else if (DEC_VALID) begin
                if (DEC_CODE_ERR) begin
                    // Corrupted symbol: abandon the frame, no framing error
                    if (w_in_frame) begin
                        r_state <= IDLE;
                        r_idx   <= 2'd0;
                    end
                end else if (DEC_K) begin
                    if (w_sof) begin
                        r_state   <= FRAME;
                        r_idx     <= 2'd0;
                        r_rec_cnt <= '0;
                    end else if (w_eof || (w_unknown_k && w_in_frame)) begin
                        r_state <= IDLE;
                        r_idx   <= 2'd0;
                    end
                end else if (w_in_frame) begin
                    if (w_rec_full) begin
                        r_state <= IDLE;
                        r_idx   <= 2'd0;
                    end else begin
                        case (r_idx)
                            2'd0: begin
                                r_byte0 <= DEC_DATA;
                                r_idx   <= 2'd1;
                            end
                            2'd1: begin
                                r_byte1 <= DEC_DATA;
                                r_idx   <= 2'd2;
                            end
                            default: begin
                                r_idx     <= 2'd0;
                                r_rec_cnt <= r_rec_cnt + REC_CNT_W'(1);
                                // A dropped record still counts toward MAX_REC
                                if (!FIFO_FULL) begin
                                    FIFO_WRITE <= 1'b1;
                                    FIFO_DATA  <= {r_byte0, r_byte1, DEC_DATA};
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end

`ifdef FEI4_RX_SOF_FLAG_EN
    // Pending flag survives dropped records so the first record that actually
    // reaches the FIFO after SOF carries the marker.
    logic r_sof_pending;

    always_ff @(posedge WCLK) begin
        if (RESET) begin
            r_sof_pending <= 1'b0;
            REC_SOF       <= 1'b0;
        end else begin
            REC_SOF <= 1'b0;
            if (!w_in_frame) begin
                r_sof_pending <= 1'b0;
            end
            if (w_write) begin
                REC_SOF       <= r_sof_pending;
                r_sof_pending <= 1'b0;
            end
            if (w_sof) begin
                r_sof_pending <= 1'b1;
            end
        end
    end
`else
    assign REC_SOF = 1'b0;
`endif

    sat_counter8 u_dec_err_cnt (
        .clk   (WCLK),
        .clear (RESET),
        .inc   (w_dec_err_inc),
        .value (DECODER_ERR_CNT)
    );

    sat_counter8 u_frame_err_cnt (
        .clk   (WCLK),
        .clear (RESET),
        .inc   (w_frame_err_inc),
        .value (FRAME_ERR_CNT)
    );

    sat_counter8 u_lost_err_cnt (
        .clk   (WCLK),
        .clear (RESET),
        .inc   (w_lost_inc),
        .value (LOST_ERR_CNT)
    );

endmodule : fei4_rx_frame_assembler
`default_nettype wire

// File: tb/tb_fei4_rx_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fei4_rx_frame_assembler
//  Purpose : Directed self-checking bench for fei4_rx_frame_assembler with
//            MAX_REC=2 so the per-frame record limit is reachable quickly.
//            Inputs change on the falling edge; outputs are checked there.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_fei4_rx_frame_assembler;

`ifdef FEI4_RX_SOF_FLAG_EN
    localparam logic SOF_FLAG = 1'b1;
`else
    localparam logic SOF_FLAG = 1'b0;
`endif

    logic        WCLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        DEC_VALID;
    logic [7:0]  DEC_DATA;
    logic        DEC_K;
    logic        DEC_CODE_ERR;
    logic        FIFO_FULL;
    logic        FIFO_WRITE;
    logic [23:0] FIFO_DATA;
    logic        REC_SOF;
    logic        IN_FRAME;
    logic [7:0]  DECODER_ERR_CNT;
    logic [7:0]  FRAME_ERR_CNT;
    logic [7:0]  LOST_ERR_CNT;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int wr_base;

    always #5 WCLK = ~WCLK;

    fei4_rx_frame_assembler #(.MAX_REC(2)) dut (
        .WCLK            (WCLK),
        .RESET           (RESET),
        .ENABLE          (ENABLE),
        .DEC_VALID       (DEC_VALID),
        .DEC_DATA        (DEC_DATA),
        .DEC_K           (DEC_K),
        .DEC_CODE_ERR    (DEC_CODE_ERR),
        .FIFO_FULL       (FIFO_FULL),
        .FIFO_WRITE      (FIFO_WRITE),
        .FIFO_DATA       (FIFO_DATA),
        .REC_SOF         (REC_SOF),
        .IN_FRAME        (IN_FRAME),
        .DECODER_ERR_CNT (DECODER_ERR_CNT),
        .FRAME_ERR_CNT   (FRAME_ERR_CNT),
        .LOST_ERR_CNT    (LOST_ERR_CNT)
    );

    // Count write strobes, one per high cycle
    always @(negedge WCLK) begin
        if (FIFO_WRITE === 1'b1) wr_cnt = wr_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one symbol for one clock, return on the following falling edge
    task automatic sym(input logic k, input logic [7:0] d, input logic err);
        DEC_VALID    = 1'b1;
        DEC_K        = k;
        DEC_DATA     = d;
        DEC_CODE_ERR = err;
        @(negedge WCLK);
    endtask

    task automatic data(input logic [7:0] d);
        sym(1'b0, d, 1'b0);
    endtask

    task automatic kcode(input logic [7:0] d);
        sym(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        DEC_VALID    = 1'b0;
        DEC_K        = 1'b0;
        DEC_DATA     = 8'h00;
        DEC_CODE_ERR = 1'b0;
        repeat (n) @(negedge WCLK);
        #1;
    endtask

    initial begin
        RESET        = 1'b1;
        ENABLE       = 1'b1;
        DEC_VALID    = 1'b0;
        DEC_DATA     = 8'h00;
        DEC_K        = 1'b0;
        DEC_CODE_ERR = 1'b0;
        FIFO_FULL    = 1'b0;
        repeat (3) @(negedge WCLK);
        RESET = 1'b0;

        // ---- reset state
        check_value("rst_write",  {31'd0, FIFO_WRITE}, 32'd0);
        check_value("rst_data",   {8'd0, FIFO_DATA}, 32'd0);
        check_value("rst_sof",    {31'd0, REC_SOF}, 32'd0);
        check_value("rst_inframe",{31'd0, IN_FRAME}, 32'd0);
        check_value("rst_dec",    {24'd0, DECODER_ERR_CNT}, 32'd0);
        check_value("rst_frm",    {24'd0, FRAME_ERR_CNT}, 32'd0);
        check_value("rst_lost",   {24'd0, LOST_ERR_CNT}, 32'd0);

        // ---- two complete records
        wr_base = wr_cnt;
        kcode(8'hFC);
        check_value("t1_inframe", {31'd0, IN_FRAME}, 32'd1);
        data(8'hAA); data(8'hBB);
        check_value("t1_nowr_early", {31'd0, FIFO_WRITE}, 32'd0);
        data(8'hCC);
        check_value("t1_wr1", {31'd0, FIFO_WRITE}, 32'd1);
        check_value("t1_data1", {8'd0, FIFO_DATA}, 32'hAABBCC);
        check_value("t1_sof1", {31'd0, REC_SOF}, {31'd0, SOF_FLAG});
        data(8'h11);
        check_value("t1_pulse_end", {31'd0, FIFO_WRITE}, 32'd0);
        check_value("t1_hold", {8'd0, FIFO_DATA}, 32'hAABBCC);
        data(8'h22); data(8'h33);
        check_value("t1_wr2", {31'd0, FIFO_WRITE}, 32'd1);
        check_value("t1_data2", {8'd0, FIFO_DATA}, 32'h112233);
        check_value("t1_sof2", {31'd0, REC_SOF}, 32'd0);
        kcode(8'hBC);
        check_value("t1_eof_idle", {31'd0, IN_FRAME}, 32'd0);
        idle(1);
        check_value("t1_wrcnt", wr_cnt - wr_base, 32'd2);
        check_value("t1_frm", {24'd0, FRAME_ERR_CNT}, 32'd0);

        // ---- truncated record at EOF
        wr_base = wr_cnt;
        kcode(8'hFC); data(8'hAA); data(8'hBB); kcode(8'hBC);
        check_value("t2_inframe", {31'd0, IN_FRAME}, 32'd0);
        check_value("t2_frm", {24'd0, FRAME_ERR_CNT}, 32'd1);
        idle(1);
        check_value("t2_wrcnt", wr_cnt - wr_base, 32'd0);

        // ---- record dropped on FIFO_FULL, SOF flag moves to next record
        wr_base = wr_cnt;
        kcode(8'hFC); data(8'h01); data(8'h02);
        FIFO_FULL = 1'b1;
        data(8'h03);
        check_value("t3_nowr", {31'd0, FIFO_WRITE}, 32'd0);
        check_value("t3_lost", {24'd0, LOST_ERR_CNT}, 32'd1);
        FIFO_FULL = 1'b0;
        data(8'h04); data(8'h05); data(8'h06);
        check_value("t3_wr", {31'd0, FIFO_WRITE}, 32'd1);
        check_value("t3_data", {8'd0, FIFO_DATA}, 32'h040506);
        check_value("t3_sof", {31'd0, REC_SOF}, {31'd0, SOF_FLAG});
        kcode(8'hBC);
        idle(1);
        check_value("t3_wrcnt", wr_cnt - wr_base, 32'd1);
        check_value("t3_frm", {24'd0, FRAME_ERR_CNT}, 32'd1);

        // ---- MAX_REC limit, then reset mid-frame
        wr_base = wr_cnt;
        kcode(8'hFC);
        for (int i = 0; i < 6; i++) data(8'(8'h40 + i));
        check_value("t4_data", {8'd0, FIFO_DATA}, 32'h434445);
        data(8'h99);
        check_value("t4_inframe", {31'd0, IN_FRAME}, 32'd0);
        check_value("t4_frm", {24'd0, FRAME_ERR_CNT}, 32'd2);
        idle(1);
        check_value("t4_wrcnt", wr_cnt - wr_base, 32'd2);
        kcode(8'hFC); data(8'hAA); data(8'hBB); data(8'hCC);
        check_value("t4_pre_inframe", {31'd0, IN_FRAME}, 32'd1);
        DEC_VALID = 1'b0;
        RESET = 1'b1;
        @(negedge WCLK);
        check_value("t4_rst_write", {31'd0, FIFO_WRITE}, 32'd0);
        check_value("t4_rst_data", {8'd0, FIFO_DATA}, 32'd0);
        check_value("t4_rst_inframe", {31'd0, IN_FRAME}, 32'd0);
        check_value("t4_rst_frm", {24'd0, FRAME_ERR_CNT}, 32'd0);
        check_value("t4_rst_lost", {24'd0, LOST_ERR_CNT}, 32'd0);
        RESET = 1'b0;
        idle(1);

        // ---- ENABLE low ignores input; falling ENABLE discards partial
        wr_base = wr_cnt;
        ENABLE = 1'b0;
        kcode(8'hFC); data(8'hAA); data(8'hBB); data(8'hCC);
        check_value("t5_inframe", {31'd0, IN_FRAME}, 32'd0);
        check_value("t5_frm", {24'd0, FRAME_ERR_CNT}, 32'd0);
        ENABLE = 1'b1;
        kcode(8'hFC); data(8'hAA); data(8'hBB);
        ENABLE = 1'b0;
        idle(1);
        check_value("t5_dis_inframe", {31'd0, IN_FRAME}, 32'd0);
        ENABLE = 1'b1;
        data(8'hCC);
        check_value("t5_frm2", {24'd0, FRAME_ERR_CNT}, 32'd1);
        idle(1);
        check_value("t5_wrcnt", wr_cnt - wr_base, 32'd0);

        // ---- decoder errors, saturation
        wr_base = wr_cnt;
        kcode(8'hFC); data(8'hAA);
        sym(1'b0, 8'h55, 1'b1);
        check_value("t6_inframe", {31'd0, IN_FRAME}, 32'd0);
        check_value("t6_dec1", {24'd0, DECODER_ERR_CNT}, 32'd1);
        for (int i = 0; i < 299; i++) sym(1'b0, 8'(i), 1'b1);
        check_value("t6_dec_sat", {24'd0, DECODER_ERR_CNT}, 32'd255);
        check_value("t6_frm", {24'd0, FRAME_ERR_CNT}, 32'd1);
        idle(1);
        check_value("t6_wrcnt", wr_cnt - wr_base, 32'd0);

        // ---- IDLE code ignored, SOF restart, unknown K, EOF outside frame
        wr_base = wr_cnt;
        kcode(8'hFC); data(8'hAA); kcode(8'h3C); data(8'hBB); data(8'hCC);
        check_value("t7_data1", {8'd0, FIFO_DATA}, 32'hAABBCC);
        data(8'h77); kcode(8'hFC);
        check_value("t7_restart", {24'd0, FRAME_ERR_CNT}, 32'd2);
        check_value("t7_restart_in", {31'd0, IN_FRAME}, 32'd1);
        data(8'h11); data(8'h22); data(8'h33);
        check_value("t7_data2", {8'd0, FIFO_DATA}, 32'h112233);
        check_value("t7_sof2", {31'd0, REC_SOF}, {31'd0, SOF_FLAG});
        kcode(8'hF7);
        check_value("t7_unk_in", {31'd0, IN_FRAME}, 32'd0);
        check_value("t7_unk_frm", {24'd0, FRAME_ERR_CNT}, 32'd3);
        kcode(8'hBC);
        check_value("t7_eof_idle", {24'd0, FRAME_ERR_CNT}, 32'd4);
        idle(1);
        check_value("t7_wrcnt", wr_cnt - wr_base, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fei4_rx_frame_assembler
`default_nettype wire
